score_digit_scanner: RTL
========================

Name: score_digit_scanner

Overview:
- Parametrised successor to the two-digit score display path.
- Converts a BIN_W-bit binary score to DIGITS BCD digits using a sequential double-dabble engine, one bit per clock.
- Holds the last completed result, flags overflow, and time-multiplexes the digits onto one shared 7-segment bus.
- Optional leading-zero blanking; sits between the score tracker and the board seven-segment outputs.

Parameters:
BIN_W, 10, width of binary input value
DIGITS, 3, number of BCD digits converted and scanned (>=1)
DWELL, 2, clock cycles each digit stays active per scan step (>=1)
BLINK_FRAMES, 8, full scan frames per blink half-period; used only when SCAN_BLINK_EN is defined

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
value_i  input  BIN_W  binary value to convert
load_i  input  1  request conversion of value_i, sampled each clock
blank_lz_i  input  1  enable leading-zero blanking
busy_o  output  1  conversion in progress
bcd_o  output  4*DIGITS  last result; digit 0 (ones) in [3:0]
ovf_o  output  1  last result overflowed
seg_o  output  7  segments {g,f,e,d,c,b,a} of active digit, 1 = lit
dig_en_o  output  DIGITS  one-hot active digit select

Behaviour:
- Reset values:
  - busy_o=0, ovf_o=0, bcd_o=0, pending cleared, FSM=IDLE.
  - Scan index=0, dwell count=0, dig_en_o=1 (digit 0), seg_o=7'b0111111.
- Conversion FSM states: IDLE, SHIFT, DONE.
  - IDLE: load_i=1 captures value_i into the shift register, clears the BCD work register, moves to SHIFT; busy_o=1 from that edge.
  - SHIFT: exactly BIN_W cycles.
    - Each cycle, every work digit >=5 gets +3 first.
    - Then {work, shift} shifts left by 1.
    - A 1 shifted out of the work MSB sets a sticky overflow bit.
  - DONE: one cycle.
    - On exit, bcd_o is loaded with the work register and ovf_o with the sticky bit.
    - If the sticky bit is set, bcd_o is all 9s (4'h9 per digit) and ovf_o=1.
- Latency: busy_o is high for exactly BIN_W+1 cycles. bcd_o/ovf_o update on the same edge that busy_o falls, unless a pending request chains, in which case busy_o stays high.
- bcd_o/ovf_o are stable between updates; partial results are never visible.
- Requests while busy:
  - load_i=1 while not IDLE stores value_i in a one-entry pending buffer; a newer value overwrites an older one.
  - On DONE exit with a request pending: go directly to SHIFT with the pending value; busy_o stays high, no gap.
  - If load_i=1 in the DONE cycle itself, value_i is used (newest wins) and pending clears.
- Reset mid-conversion: aborts; bcd_o returns to 0 and the pending request is dropped.
- Scan:
  - Dwell counter counts 0..DWELL-1; at wrap, index advances 0..DIGITS-1 and wraps to 0.
  - dig_en_o = one-hot(index), registered.
  - seg_o is combinational from the registered index and bcd_o (hex decode; A-F cannot occur).
  - Scan runs continuously, independent of busy_o.
- Leading-zero blanking: when blank_lz_i=1, digit k>0 shows seg_o=0 if digits k..DIGITS-1 are all zero. Digit 0 is never blanked; dig_en_o is unaffected.

Optional Feature:
- Macro SCAN_BLINK_EN.
- Defined:
  - Adds input blink_i (1 bit).
  - A frame counter counts completed scans, i.e. index wrapping DIGITS-1 to 0.
  - The blink phase toggles every BLINK_FRAMES frames; phase resets to visible.
  - While blink_i=1 and phase=hidden, seg_o=0.
  - When blink_i=0, the phase counter is held at visible.
- Not defined: no blink_i port, no frame counter; seg_o is never forced off.

Test Plan:
- Reset with defaults -> dig_en_o=3'b001, seg_o=7'b0111111, bcd_o=12'h000, busy_o=0, ovf_o=0.
- load_i pulse with value_i=437 -> busy_o high 11 cycles; bcd_o=12'h437 and ovf_o=0 on the edge busy_o falls.
- value_i=999 -> bcd_o=12'h999, ovf_o=0; then value_i=1000 -> bcd_o=12'h999, ovf_o=1.
- load 437, then load 5 on cycle 4 of busy -> busy_o high 22 cycles continuously; bcd_o=12'h437 after 11 cycles, then 12'h005.
- bcd_o=12'h007, blank_lz_i=1 -> dig_en_o cycles 001,010,100 at 2 cycles each; seg_o=7'b0000111 on digit 0, 0 on digits 1 and 2. With blank_lz_i=0, seg_o=7'b0111111 on digits 1 and 2.
- bcd_o=12'h105, blank_lz_i=1 -> middle digit shows 7'b0111111 (not blanked); assert rst mid-conversion -> busy_o=0 and bcd_o=0 immediately.

Source files
------------

// File: rtl/score_digit_scanner.sv
// Binary-to-BCD score converter (sequential double-dabble, one bit per clock)
// with a time-multiplexed 7-segment scan. Define SCAN_BLINK_EN to add blink_i.
module score_digit_scanner #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3,
    parameter int DWELL  = 2
`ifdef SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      value_i,
    input  logic                  load_i,
    input  logic                  blank_lz_i,
`ifdef SCAN_BLINK_EN
    input  logic                  blink_i,
`endif
    output logic                  busy_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  ovf_o,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     dig_en_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int IX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [IX_W-1:0]  IX_LAST  = IX_W'(DIGITS - 1);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] w);
        logic [BCD_W-1:0] r;
        r = w;
        for (int k = 0; k < DIGITS; k++) begin
            if (w[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = w[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = w[4*k +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [BCD_W-1:0] all_nines();
        logic [BCD_W-1:0] r;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'h9;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            4'hF:    s = 7'b1110001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    state_t             state_r;
    logic [BIN_W-1:0]   shift_r;
    logic [BCD_W-1:0]   work_r;
    logic [BCD_W-1:0]   adj_s;
    logic               sticky_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               pend_r;
    logic [BIN_W-1:0]   pend_val_r;
    logic               busy_r;
    logic [BCD_W-1:0]   bcd_r;
    logic               ovf_r;

    logic [DW_W-1:0]    dwell_r;
    logic [IX_W-1:0]    idx_r;
    logic [DIGITS-1:0]  dig_en_r;
    logic               frame_done_s;
    logic [3:0]         digit_s;
    logic               upper_zero_s;
    logic               blank_s;
    logic               hide_s;

    assign adj_s = add3_all(work_r);

    // Conversion FSM: capture, BIN_W shift steps, one DONE cycle that publishes the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            shift_r    <= '0;
            work_r     <= '0;
            sticky_r   <= 1'b0;
            cnt_r      <= '0;
            pend_r     <= 1'b0;
            pend_val_r <= '0;
            busy_r     <= 1'b0;
            bcd_r      <= '0;
            ovf_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (load_i) begin
                        shift_r  <= value_i;
                        work_r   <= '0;
                        sticky_r <= 1'b0;
                        cnt_r    <= '0;
                        busy_r   <= 1'b1;
                        state_r  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // add-3 correction precedes the shift; bits leaving the work MSB mean overflow
                    work_r   <= {adj_s[BCD_W-2:0], shift_r[BIN_W-1]};
                    shift_r  <= shift_r << 1;
                    sticky_r <= sticky_r | adj_s[BCD_W-1];
                    if (cnt_r == CNT_LAST) begin
                        state_r <= S_DONE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                    if (load_i) begin
                        pend_r     <= 1'b1;
                        pend_val_r <= value_i;
                    end
                end
                S_DONE: begin
                    bcd_r <= sticky_r ? all_nines() : work_r;
                    ovf_r <= sticky_r;
                    if (load_i || pend_r) begin
                        shift_r  <= load_i ? value_i : pend_val_r;
                        work_r   <= '0;
                        sticky_r <= 1'b0;
                        cnt_r    <= '0;
                        pend_r   <= 1'b0;
                        state_r  <= S_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    pend_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign frame_done_s = (dwell_r == DW_LAST) && (idx_r == IX_LAST);

    // Scan sequencer: dwell counter, digit index and its registered one-hot select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_r  <= '0;
            idx_r    <= '0;
            dig_en_r <= DIGITS'(1);
        end else if (dwell_r == DW_LAST) begin
            dwell_r <= '0;
            if (idx_r == IX_LAST) begin
                idx_r    <= '0;
                dig_en_r <= DIGITS'(1);
            end else begin
                idx_r    <= idx_r + 1'b1;
                dig_en_r <= dig_en_r << 1;
            end
        end else begin
            dwell_r <= dwell_r + 1'b1;
        end
    end

`ifdef SCAN_BLINK_EN
    localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);
    logic [FR_W-1:0] frame_r;
    logic            phase_r;

    // Blink phase: toggles every BLINK_FRAMES completed scans, parked visible when blink is off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_r <= '0;
            phase_r <= 1'b0;
        end else if (!blink_i) begin
            frame_r <= '0;
            phase_r <= 1'b0;
        end else if (frame_done_s) begin
            if (frame_r == FR_LAST) begin
                frame_r <= '0;
                phase_r <= ~phase_r;
            end else begin
                frame_r <= frame_r + 1'b1;
            end
        end else begin
            frame_r <= frame_r;
        end
    end

    assign hide_s = blink_i & phase_r;
`else
    assign hide_s = 1'b0;
`endif

    // Active digit selection and leading-zero detection (scan from the top digit down)
    always_comb begin
        digit_s      = 4'h0;
        upper_zero_s = 1'b1;
        blank_s      = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero_s = upper_zero_s & (bcd_r[4*k +: 4] == 4'h0);
            digit_s = (idx_r == IX_W'(k)) ? bcd_r[4*k +: 4] : digit_s;
            blank_s = (idx_r == IX_W'(k)) ? (blank_lz_i & (k > 32'sd0) & upper_zero_s) : blank_s;
        end
    end

    // Segment bus for the active digit
    always_comb begin
        if (blank_s || hide_s) begin
            seg_o = 7'b0000000;
        end else begin
            seg_o = seg_decode(digit_s);
        end
    end

    assign busy_o   = busy_r;
    assign bcd_o    = bcd_r;
    assign ovf_o    = ovf_r;
    assign dig_en_o = dig_en_r;

endmodule
